fpnew_special_gen: RTL and testbench

FPNEW_SPECIAL_GEN -- requirements
Module: fpnew_special_gen

---
 rtl/fpnew_special_gen.sv | 150 +++++++++++++++
 tb/tb_fpnew_special_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_special_gen.sv
// Generates IEEE special/boundary values (zero, inf, NaNs, extremes, one) through a valid/ready pipeline.
// Define FPNEW_SPECIAL_GEN_BOX_EN to NaN-box results narrower than Flen; otherwise the upper bits are zero.
module fpnew_special_gen #(
  parameter int unsigned FpFormat    = 0,
  parameter int unsigned Flen        = 32,
  parameter int unsigned NumPipeRegs = 1,
  parameter int unsigned TagWidth    = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [2:0]          class_i,
  input  logic                sign_i,
  input  logic [TagWidth-1:0] tag_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                flush_i,
  output logic [Flen-1:0]     result_o,
  output logic [TagWidth-1:0] tag_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                busy_o
);

  // Format order: FP32, FP64, FP16, FP8, FP16ALT
  function automatic int unsigned exp_bits(input int unsigned fmt);
    case (fmt)
      1:       return 11;
      2, 3:    return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned man_bits(input int unsigned fmt);
    case (fmt)
      1:       return 52;
      2:       return 10;
      3:       return 2;
      4:       return 7;
      default: return 23;
    endcase
  endfunction

  localparam int unsigned E     = exp_bits(FpFormat);
  localparam int unsigned M     = man_bits(FpFormat);
  localparam int unsigned WIDTH = 1 + E + M;

`ifdef FPNEW_SPECIAL_GEN_BOX_EN
  localparam logic BOX_BIT = 1'b1;
`else
  localparam logic BOX_BIT = 1'b0;
`endif

  localparam logic [E-1:0] EXP_ONES = {E{1'b1}};
  localparam logic [E-1:0] EXP_MAXN = {{(E-1){1'b1}}, 1'b0};
  localparam logic [E-1:0] EXP_BIAS = {1'b0, {(E-1){1'b1}}};
  localparam logic [E-1:0] EXP_ONE  = {{(E-1){1'b0}}, 1'b1};
  localparam logic [M-1:0] MAN_ONES = {M{1'b1}};
  localparam logic [M-1:0] MAN_MSB  = {1'b1, {(M-1){1'b0}}};
  localparam logic [M-1:0] MAN_LSB  = {{(M-1){1'b0}}, 1'b1};

  logic            gen_sign;
  logic [E-1:0]    gen_exp;
  logic [M-1:0]    gen_man;
  logic [Flen-1:0] gen_res;

  always_comb begin
    gen_sign = sign_i;
    gen_exp  = '0;
    gen_man  = '0;
    case (class_i)
      3'd0: ;
      3'd1: gen_exp = EXP_ONES;
      3'd2: begin gen_sign = 1'b0; gen_exp = EXP_ONES; gen_man = MAN_MSB; end
      3'd3: begin gen_sign = 1'b0; gen_exp = EXP_ONES; gen_man = MAN_LSB; end
      3'd4: begin gen_exp = EXP_MAXN; gen_man = MAN_ONES; end
      3'd5: gen_exp = EXP_ONE;
      3'd6: gen_man = MAN_LSB;
      3'd7: gen_exp = EXP_BIAS;
    endcase
  end

  if (Flen > WIDTH) begin : g_box
    assign gen_res = {{(Flen-WIDTH){BOX_BIT}}, gen_sign, gen_exp, gen_man};
  end else begin : g_nobox
    assign gen_res = {gen_sign, gen_exp, gen_man};
  end

  if (NumPipeRegs == 0) begin : g_comb
    assign result_o    = gen_res;
    assign tag_o       = tag_i;
    assign out_valid_o = in_valid_i;
    assign in_ready_o  = out_ready_i;
    assign busy_o      = 1'b0;
  end else begin : g_pipe
    localparam int N = NumPipeRegs;

    logic [N-1:0]        valid_q;
    logic [N-1:0]        up_valid;
    logic [N:0]          ready;
    logic [Flen-1:0]     res_q  [N];
    logic [TagWidth-1:0] tag_q  [N];
    logic [Flen-1:0]     up_res [N];
    logic [TagWidth-1:0] up_tag [N];

    // A stage may take new data when empty or when its content leaves this cycle
    assign ready[N] = out_ready_i;
    for (genvar i = 0; i < N; i++) begin : g_ready
      assign ready[i] = ~valid_q[i] | ready[i+1];
    end

    assign up_valid = N'({valid_q, in_valid_i});

    always_comb begin
      up_res[0] = gen_res;
      up_tag[0] = tag_i;
      for (int i = 1; i < N; i++) begin
        up_res[i] = res_q[i-1];
        up_tag[i] = tag_q[i-1];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= '0;
      end else if (flush_i) begin
        valid_q <= '0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (ready[i]) valid_q[i] <= up_valid[i];
        end
      end
    end

    always_ff @(posedge clk_i) begin
      for (int i = 0; i < N; i++) begin
        if (ready[i] && up_valid[i]) begin
          res_q[i] <= up_res[i];
          tag_q[i] <= up_tag[i];
        end
      end
    end

    assign result_o    = res_q[N-1];
    assign tag_o       = tag_q[N-1];
    assign out_valid_o = valid_q[N-1];
    assign in_ready_o  = ready[0] & ~flush_i;
    assign busy_o      = |valid_q;
  end

endmodule

// File: tb/tb_fpnew_special_gen.sv
// Scoreboard bench: a 3-stage FP32-in-64 instance driven through directed vectors,
// plus a combinational (0-stage) instance checked directly.
module tb_fpnew_special_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef FPNEW_SPECIAL_GEN_BOX_EN
  localparam logic [31:0] BOX_HI = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] BOX_HI = 32'h0000_0000;
`endif

  // pipelined instance
  logic [2:0]  a_class = '0;
  logic        a_sign = 1'b0;
  logic [3:0]  a_tag = '0;
  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic        a_flush = 1'b0;
  logic [63:0] a_result;
  logic [3:0]  a_tag_out;
  logic        a_out_valid;
  logic        a_out_ready = 1'b0;
  logic        a_busy;

  fpnew_special_gen #(.FpFormat(0), .Flen(64), .NumPipeRegs(3), .TagWidth(4)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .class_i(a_class), .sign_i(a_sign), .tag_i(a_tag),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .flush_i(a_flush),
    .result_o(a_result), .tag_o(a_tag_out), .out_valid_o(a_out_valid),
    .out_ready_i(a_out_ready), .busy_o(a_busy)
  );

  // combinational instance
  logic [2:0]  c_class = '0;
  logic        c_sign = 1'b0;
  logic [0:0]  c_tag = '0;
  logic        c_in_valid = 1'b0;
  logic        c_in_ready;
  logic        c_flush = 1'b0;
  logic [31:0] c_result;
  logic [0:0]  c_tag_out;
  logic        c_out_valid;
  logic        c_out_ready = 1'b0;
  logic        c_busy;

  fpnew_special_gen #(.FpFormat(0), .Flen(32), .NumPipeRegs(0), .TagWidth(1)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .class_i(c_class), .sign_i(c_sign), .tag_i(c_tag),
    .in_valid_i(c_in_valid), .in_ready_o(c_in_ready), .flush_i(c_flush),
    .result_o(c_result), .tag_o(c_tag_out), .out_valid_o(c_out_valid),
    .out_ready_i(c_out_ready), .busy_o(c_busy)
  );

  typedef struct packed {
    logic [3:0]  tag;
    logic [63:0] res;
  } item_t;

  item_t sb[$];
  int errors = 0;
  int checks = 0;
  int received = 0;
  int stalls = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hand-written FP32 encodings
  function automatic logic [63:0] model(input logic [2:0] cls, input logic s);
    logic [31:0] v;
    case (cls)
      3'd0: v = 32'h0000_0000;
      3'd1: v = 32'h7F80_0000;
      3'd2: v = 32'h7FC0_0000;
      3'd3: v = 32'h7F80_0001;
      3'd4: v = 32'h7F7F_FFFF;
      3'd5: v = 32'h0080_0000;
      3'd6: v = 32'h0000_0001;
      default: v = 32'h3F80_0000;
    endcase
    if (cls != 3'd2 && cls != 3'd3) v[31] = s;
    return {BOX_HI, v};
  endfunction

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [2:0] cls, input logic s, input logic [3:0] tg);
    item_t it;
    bit done = 0;
    a_class = cls;
    a_sign = s;
    a_tag = tg;
    a_in_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (a_in_ready) begin
        it.tag = tg;
        it.res = model(cls, s);
        sb.push_back(it);
        done = 1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: compare whatever is presented, pop on transfer
  always @(negedge clk) begin
    if (rst_n && a_out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {60'd0, a_tag_out}, 64'hFFFF);
      end else begin
        chk("result", a_result, sb[0].res);
        chk("tag", {60'd0, a_tag_out}, {60'd0, sb[0].tag});
        if (a_out_ready) begin
          void'(sb.pop_front());
          received++;
        end
      end
    end
  end

  initial begin
    int rcv0;
    logic [63:0] m;

    #1;
    chk("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("rst_busy", {63'd0, a_busy}, 64'd0);
    chk("rst_in_ready", {63'd0, a_in_ready}, 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Combinational instance
    c_class = 3'd5; c_sign = 1'b1; c_tag = 1'b1; c_in_valid = 1'b1; c_out_ready = 1'b0;
    #1;
    chk("c_min_norm_neg", {32'd0, c_result}, 64'h8080_0000);
    chk("c_out_valid", {63'd0, c_out_valid}, 64'd1);
    chk("c_in_ready_low", {63'd0, c_in_ready}, 64'd0);
    chk("c_busy", {63'd0, c_busy}, 64'd0);
    chk("c_tag", {63'd0, c_tag_out}, 64'd1);
    c_class = 3'd2; c_out_ready = 1'b1; c_in_valid = 1'b0;
    #1;
    chk("c_qnan_pos", {32'd0, c_result}, 64'h7FC0_0000);
    chk("c_in_ready_high", {63'd0, c_in_ready}, 64'd1);
    chk("c_out_valid_low", {63'd0, c_out_valid}, 64'd0);

    // Full class/sign sweep, continuous downstream ready
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    stalls = 0;
    for (int k = 0; k < 16; k++) send(3'(k >> 1), k[0], 4'(k));
    a_in_valid = 1'b0;
    chk("burst_no_stall", 64'(stalls), 64'd0);
    drain();
    m = model(3'd1, 1'b1);
    chk("model_inf_neg", m, {BOX_HI, 32'hFF80_0000});

    // Five tagged values with downstream stalled for three cycles
    rcv0 = received;
    fork
      begin
        for (int t = 1; t <= 5; t++) send(3'(t), 1'b0, 4'(t));
        a_in_valid = 1'b0;
      end
      begin
        a_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 a_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 a_out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_count", 64'(received - rcv0), 64'd5);

    // Fill with downstream blocked, then flush
    a_out_ready = 1'b0;
    send(3'd4, 1'b1, 4'd7);
    send(3'd6, 1'b0, 4'd8);
    send(3'd0, 1'b1, 4'd9);
    a_in_valid = 1'b0;
    chk("full_in_ready_low", {63'd0, a_in_ready}, 64'd0);
    chk("full_busy", {63'd0, a_busy}, 64'd1);
    repeat (2) @(posedge clk);
    #1 a_flush = 1'b1;
    a_in_valid = 1'b1;
    a_class = 3'd7;
    @(negedge clk);
    chk("flush_in_ready_low", {63'd0, a_in_ready}, 64'd0);
    @(posedge clk);
    #1 a_flush = 1'b0;
    a_in_valid = 1'b0;
    sb.delete();
    chk("flush_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("flush_busy", {63'd0, a_busy}, 64'd0);

    // Asynchronous reset with two values in flight
    send(3'd1, 1'b0, 4'd3);
    send(3'd7, 1'b1, 4'd4);
    a_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("arst_busy", {63'd0, a_busy}, 64'd0);
    chk("arst_in_ready", {63'd0, a_in_ready}, 64'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 a_out_ready = 1'b1;
    send(3'd7, 1'b0, 4'd5);
    a_in_valid = 1'b0;
    chk("lat_edge0", {63'd0, a_out_valid}, 64'd0);
    @(posedge clk);
    #1 chk("lat_edge1", {63'd0, a_out_valid}, 64'd0);
    @(posedge clk);
    #1 chk("lat_edge2", {63'd0, a_out_valid}, 64'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
